// File: rtl/cohort_mreq_pkg.sv
// cohort_mreq_pkg: shared types for the cohort
// strided load-request generator.
package cohort_mreq_pkg;

   function automatic int chan_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int MREQ_NUM_CHAN = 2;
   localparam int MREQ_ADDR_W   = 32;
   localparam int MREQ_SIZE_W   = 3;
   localparam int MREQ_LEN_W    = 4;
   localparam int MREQ_MAX_OUT  = 4;
   localparam int MREQ_TAG_W    = 4;
   localparam int MREQ_CHAN_W   = chan_w(MREQ_NUM_CHAN);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      DONE
   } chan_state_e;

   typedef struct packed {
      logic [MREQ_ADDR_W-1:0] addr;
      logic [MREQ_SIZE_W-1:0] size;
      logic [MREQ_LEN_W-1:0]  len;
   } chan_cfg_t;

   typedef struct packed {
      logic [MREQ_ADDR_W-1:0] addr;
      logic [MREQ_SIZE_W-1:0] size;
      logic [MREQ_CHAN_W-1:0] chan;
      logic [MREQ_TAG_W-1:0]  tag;
   } mem_req_t;

endpackage

// File: rtl/cohort_mreq_gen_if.sv
// cohort_mreq_gen_if: config, request and response
// signals of the load-request generator.
interface cohort_mreq_gen_if
   import cohort_mreq_pkg::*;
#(
   parameter int NUM_CHAN = MREQ_NUM_CHAN,
   parameter int ADDR_W   = MREQ_ADDR_W,
   parameter int SIZE_W   = MREQ_SIZE_W,
   parameter int LEN_W    = MREQ_LEN_W,
   parameter int TAG_W    = MREQ_TAG_W
) ();
   localparam int CW = chan_w(NUM_CHAN);

   logic              conf_valid;
   logic              conf_ready;
   logic [CW-1:0]     conf_chan;
   logic [ADDR_W-1:0] conf_addr;
   logic [SIZE_W-1:0] conf_size;
   logic [LEN_W-1:0]  conf_len;
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic [SIZE_W-1:0] req_size;
   logic [CW-1:0]     req_chan;
   logic [TAG_W-1:0]  req_tag;
   logic              resp_valid;
   logic [CW-1:0]     resp_chan;
   logic [NUM_CHAN-1:0] busy;
   logic [NUM_CHAN-1:0] done;
   logic              err;

   modport master (
      output conf_valid, conf_chan, conf_addr,
      output conf_size, conf_len, req_ready,
      output resp_valid, resp_chan,
      input  conf_ready, req_valid, req_addr,
      input  req_size, req_chan, req_tag,
      input  busy, done, err
   );

   modport slave (
      input  conf_valid, conf_chan, conf_addr,
      input  conf_size, conf_len, req_ready,
      input  resp_valid, resp_chan,
      output conf_ready, req_valid, req_addr,
      output req_size, req_chan, req_tag,
      output busy, done, err
   );

endinterface

// File: rtl/cohort_rr_arb.sv
// cohort_rr_arb: round-robin arbiter; the pointer
// moves past the winner only when not held.
module cohort_rr_arb
   import cohort_mreq_pkg::*;
#(
   parameter int N = 2,
   localparam int IW = chan_w(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  req_i,
   input  logic          hold_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          vld_o
);
   logic [IW-1:0] ptr_q, ptr_d;

   // first requester at or after the pointer wins
   always_comb begin
      int j;
      vld_o = 1'b0;
      idx_o = '0;
      gnt_o = '0;
      for (int i = 0; i < N; i++) begin
         j = (int'(ptr_q) + i) % N;
         if (!vld_o && req_i[j]) begin
            vld_o = 1'b1;
            idx_o = IW'(j);
         end
      end
      if (vld_o) gnt_o[idx_o] = 1'b1;
   end

   // priority restarts just after the winner
   always_comb begin
      ptr_d = ptr_q;
      if (vld_o && !hold_i)
         ptr_d = (int'(idx_o) == N - 1) ? '0 : idx_o + 1'b1;
   end

   // pointer register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end

endmodule

// File: rtl/cohort_mreq_gen.sv
// cohort_mreq_gen: per-channel strided load issue
// with registered round-robin grant.
module cohort_mreq_gen
   import cohort_mreq_pkg::*;
#(
   parameter int NUM_CHAN = MREQ_NUM_CHAN,
   parameter int ADDR_W   = MREQ_ADDR_W,
   parameter int SIZE_W   = MREQ_SIZE_W,
   parameter int LEN_W    = MREQ_LEN_W,
   parameter int MAX_OUT  = MREQ_MAX_OUT,
   parameter int TAG_W    = MREQ_TAG_W
) (
   input  logic             clk,
   input  logic             rst_n,
   cohort_mreq_gen_if.slave bus
);
   localparam int CW = chan_w(NUM_CHAN);
   localparam int OW = $clog2(MAX_OUT + 1);

   chan_state_e      st_q  [NUM_CHAN];
   chan_state_e      st_d  [NUM_CHAN];
   chan_cfg_t        cfg_q [NUM_CHAN];
   chan_cfg_t        cfg_d [NUM_CHAN];
   logic [LEN_W-1:0] iss_q [NUM_CHAN];
   logic [LEN_W-1:0] iss_d [NUM_CHAN];
   logic [OW-1:0]    out_q [NUM_CHAN];
   logic [OW-1:0]    out_d [NUM_CHAN];
   logic             err_q, err_d;
   logic             rv_q, rv_d;
   mem_req_t         req_q, req_d;

   logic [NUM_CHAN-1:0] elig, gnt;
   logic [NUM_CHAN-1:0] hs_c, rsp_c, acc_c;
   logic [CW-1:0]       gidx;
   logic                gvld, hs, ld, acc;

   assign hs  = rv_q && bus.req_ready;
   assign ld  = !rv_q || bus.req_ready;
   assign acc = bus.conf_valid && bus.conf_ready;

   assign bus.conf_ready =
      (int'(bus.conf_chan) < NUM_CHAN) &&
      (st_q[bus.conf_chan] == IDLE);

   assign bus.req_valid = rv_q;
   assign bus.req_addr  = req_q.addr;
   assign bus.req_size  = req_q.size;
   assign bus.req_chan  = req_q.chan;
   assign bus.req_tag   = req_q.tag;
   assign bus.err       = err_q;

   // per-channel strobes; the pending request counts
   // against the limit once it handshakes
   always_comb begin
      for (int c = 0; c < NUM_CHAN; c++) begin
         hs_c[c]  = hs && (req_q.chan == CW'(c));
         rsp_c[c] = bus.resp_valid &&
                    (bus.resp_chan == CW'(c));
         acc_c[c] = acc && (bus.conf_chan == CW'(c));
         elig[c]  = (st_q[c] == ISSUE) &&
                    (iss_q[c] != cfg_q[c].len) &&
                    ((int'(out_q[c]) + int'(hs_c[c]))
                     < MAX_OUT);
      end
   end

   cohort_rr_arb #(.N(NUM_CHAN)) u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .req_i  (elig),
      .hold_i (!ld),
      .gnt_o  (gnt),
      .idx_o  (gidx),
      .vld_o  (gvld)
   );

   // config latch, issue index and outstanding count;
   // a response with nothing outstanding is dropped
   always_comb begin
      err_d = err_q;
      for (int c = 0; c < NUM_CHAN; c++) begin
         cfg_d[c] = cfg_q[c];
         iss_d[c] = iss_q[c];
         out_d[c] = out_q[c];
         if (rsp_c[c] && out_q[c] == '0) err_d = 1'b1;
         if (acc_c[c]) begin
            cfg_d[c].addr = ADDR_W'(bus.conf_addr);
            cfg_d[c].size = SIZE_W'(bus.conf_size);
            cfg_d[c].len  = bus.conf_len;
            iss_d[c] = '0;
            out_d[c] = '0;
         end else begin
            if (ld && gnt[c]) iss_d[c] = iss_q[c] + 1'b1;
            out_d[c] = out_q[c] + OW'(hs_c[c]) -
                       OW'(rsp_c[c] && out_q[c] != '0);
         end
      end
   end

   // channel next-state
   always_comb begin
      for (int c = 0; c < NUM_CHAN; c++) begin
         st_d[c] = st_q[c];
         unique case (st_q[c])
            IDLE:
               if (acc_c[c])
                  st_d[c] = (bus.conf_len == '0) ? DONE : ISSUE;
            ISSUE:
               if (hs_c[c] && iss_q[c] == cfg_q[c].len)
                  st_d[c] = DRAIN;
            DRAIN:
               if (out_d[c] == '0) st_d[c] = DONE;
            DONE:
               st_d[c] = IDLE;
            default:
               st_d[c] = IDLE;
         endcase
      end
   end

   // channel status outputs
   always_comb begin
      for (int c = 0; c < NUM_CHAN; c++) begin
         bus.busy[c] = (st_q[c] != IDLE);
         bus.done[c] = (st_q[c] == DONE);
      end
   end

   // request register loads whenever the slot frees
   always_comb begin
      rv_d  = rv_q;
      req_d = req_q;
      if (ld) begin
         rv_d = gvld;
         if (gvld) begin
            req_d.addr = cfg_q[gidx].addr +
               (ADDR_W'(iss_q[gidx]) << cfg_q[gidx].size);
            req_d.size = cfg_q[gidx].size;
            req_d.chan = gidx;
            req_d.tag  = TAG_W'(iss_q[gidx]);
         end
      end
   end

   // channel state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NUM_CHAN; c++) st_q[c] <= IDLE;
      end else begin
         for (int c = 0; c < NUM_CHAN; c++) st_q[c] <= st_d[c];
      end
   end

   // datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NUM_CHAN; c++) begin
            cfg_q[c] <= '0;
            iss_q[c] <= '0;
            out_q[c] <= '0;
         end
         err_q <= 1'b0;
         rv_q  <= 1'b0;
         req_q <= '0;
      end else begin
         for (int c = 0; c < NUM_CHAN; c++) begin
            cfg_q[c] <= cfg_d[c];
            iss_q[c] <= iss_d[c];
            out_q[c] <= out_d[c];
         end
         err_q <= err_d;
         rv_q  <= rv_d;
         req_q <= req_d;
      end
   end

endmodule

// File: tb/tb_cohort_mreq_gen.sv
// tb_cohort_mreq_gen: directed bench for the
// cohort strided load-request generator.
`timescale 1ns/1ps
module tb_cohort_mreq_gen;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   cohort_mreq_gen_if bus ();
   cohort_mreq_gen dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  tag;
      logic        chan;
   } hs_t;

   hs_t  log_q [$];
   int   dcnt [2] = '{0, 0};
   int   n_chk, n_pass;
   logic auto_en = 1'b0;
   logic man_v = 1'b0;
   logic man_c = 1'b0;
   logic p1_v = 1'b0, p2_v = 1'b0;
   logic p1_c = 1'b0, p2_c = 1'b0;

   assign bus.resp_valid = man_v | p2_v;
   assign bus.resp_chan  = p2_v ? p2_c : man_c;

   // log handshakes and done pulses; auto-respond 2 cycles later
   always @(posedge clk) begin
      p1_v <= auto_en && bus.req_valid && bus.req_ready;
      p1_c <= bus.req_chan;
      p2_v <= p1_v;
      p2_c <= p1_c;
      if (bus.req_valid && bus.req_ready)
         log_q.push_back('{addr: bus.req_addr,
                           tag: bus.req_tag,
                           chan: bus.req_chan});
      for (int c = 0; c < 2; c++)
         if (bus.done[c]) dcnt[c] <= dcnt[c] + 1;
   end

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg(input logic ch, input logic [31:0] a,
                      input logic [2:0] s, input logic [3:0] l);
      bus.conf_valid = 1'b1;
      bus.conf_chan  = ch;
      bus.conf_addr  = a;
      bus.conf_size  = s;
      bus.conf_len   = l;
      #1;
      chk("cfg_ready", 32'(bus.conf_ready), 1);
      tick();
      bus.conf_valid = 1'b0;
   endtask

   task automatic wait_done(input int ch, input int budget);
      int n = 0;
      while (bus.done[ch] !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      chk("wait_done", 32'(bus.done[ch]), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int l0, d0, d1, n;
      logic [31:0] e1 [4];
      logic [31:0] e3 [6];
      n_chk = 0;
      n_pass = 0;
      rst_n = 1'b1;
      bus.conf_valid = 1'b0;
      bus.conf_chan  = 1'b0;
      bus.conf_addr  = '0;
      bus.conf_size  = '0;
      bus.conf_len   = '0;
      bus.req_ready  = 1'b0;
      #1 rst_n = 1'b0;
      repeat (2) tick();
      chk("rst_req_valid", 32'(bus.req_valid), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_err", 32'(bus.err), 0);
      chk("rst_req_addr", bus.req_addr, 0);
      chk("rst_req_tag", 32'(bus.req_tag), 0);
      rst_n = 1'b1;
      tick();

      // basic strided job
      bus.req_ready = 1'b1;
      auto_en = 1'b1;
      l0 = log_q.size();
      d0 = dcnt[0];
      cfg(1'b0, 32'hdeadbeef, 3'd3, 4'd4);
      chk("t1_busy", 32'(bus.busy[0]), 1);
      chk("t1_latency", 32'(bus.req_valid), 0);
      tick();
      chk("t1_first_valid", 32'(bus.req_valid), 1);
      chk("t1_first_addr", bus.req_addr, 32'hdeadbeef);
      wait_done(0, 40);
      chk("t1_busy_in_done", 32'(bus.busy[0]), 1);
      tick();
      chk("t1_done_drop", 32'(bus.done[0]), 0);
      chk("t1_busy_drop", 32'(bus.busy[0]), 0);
      repeat (3) tick();
      e1 = '{32'hdeadbeef, 32'hdeadbef7,
             32'hdeadbeff, 32'hdeadbf07};
      chk("t1_count", log_q.size() - l0, 4);
      for (int i = 0; i < 4; i++) begin
         chk("t1_addr", log_q[l0+i].addr, e1[i]);
         chk("t1_tag", 32'(log_q[l0+i].tag), i);
      end
      chk("t1_done_cnt", dcnt[0] - d0, 1);
      chk("t1_err", 32'(bus.err), 0);

      // two channels interleave
      l0 = log_q.size();
      d0 = dcnt[0];
      d1 = dcnt[1];
      cfg(1'b0, 32'h1000, 3'd2, 4'd3);
      cfg(1'b1, 32'h2000, 3'd2, 4'd3);
      n = 0;
      while (bus.busy != 2'b00 && n < 60) begin
         tick();
         n++;
      end
      chk("t3_idle", 32'(bus.busy), 0);
      tick();
      e3 = '{32'h1000, 32'h2000, 32'h1004,
             32'h2004, 32'h1008, 32'h2008};
      chk("t3_count", log_q.size() - l0, 6);
      for (int i = 0; i < 6; i++) begin
         chk("t3_addr", log_q[l0+i].addr, e3[i]);
         chk("t3_chan", 32'(log_q[l0+i].chan), i % 2);
      end
      chk("t3_done0", dcnt[0] - d0, 1);
      chk("t3_done1", dcnt[1] - d1, 1);

      // zero-length job
      l0 = log_q.size();
      d1 = dcnt[1];
      cfg(1'b1, 32'h3000, 3'd0, 4'd0);
      chk("t4_len0_done", 32'(bus.done[1]), 1);
      chk("t4_len0_noreq", 32'(bus.req_valid), 0);
      tick();
      chk("t4_len0_done_drop", 32'(bus.done[1]), 0);
      chk("t4_len0_idle", 32'(bus.busy[1]), 0);
      chk("t4_len0_count", log_q.size() - l0, 0);
      chk("t4_len0_pulses", dcnt[1] - d1, 1);

      // address wrap
      l0 = log_q.size();
      cfg(1'b0, 32'hfffffffc, 3'd2, 4'd2);
      wait_done(0, 40);
      repeat (3) tick();
      chk("t4_wrap_count", log_q.size() - l0, 2);
      chk("t4_wrap_a0", log_q[l0].addr, 32'hfffffffc);
      chk("t4_wrap_a1", log_q[l0+1].addr, 32'h00000000);
      chk("t4_wrap_tag1", 32'(log_q[l0+1].tag), 1);

      // unexpected response on idle channel
      auto_en = 1'b0;
      chk("err_before", 32'(bus.err), 0);
      man_v = 1'b1;
      man_c = 1'b1;
      tick();
      man_v = 1'b0;
      chk("err_set", 32'(bus.err), 1);
      repeat (3) tick();
      chk("err_sticky", 32'(bus.err), 1);

      // outstanding limit, busy reconfig, stall
      l0 = log_q.size();
      cfg(1'b0, 32'h4000, 3'd3, 4'd8);
      repeat (8) tick();
      chk("t2_limit_count", log_q.size() - l0, 4);
      chk("t2_limit_idle", 32'(bus.req_valid), 0);
      bus.conf_valid = 1'b1;
      bus.conf_chan  = 1'b0;
      bus.conf_addr  = 32'h5000;
      bus.conf_size  = 3'd0;
      bus.conf_len   = 4'd1;
      #1;
      chk("t4_busy_not_ready", 32'(bus.conf_ready), 0);
      tick();
      bus.conf_valid = 1'b0;
      chk("t4_busy_kept", 32'(bus.busy[0]), 1);
      chk("t4_busy_noreq", 32'(bus.req_valid), 0);
      man_v = 1'b1;
      man_c = 1'b0;
      tick();
      man_v = 1'b0;
      bus.req_ready = 1'b0;
      tick();
      chk("t2_resume_valid", 32'(bus.req_valid), 1);
      chk("t2_resume_addr", bus.req_addr, 32'h4020);
      chk("t2_resume_tag", 32'(bus.req_tag), 4);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t2_stall_valid", 32'(bus.req_valid), 1);
         chk("t2_stall_addr", bus.req_addr, 32'h4020);
         chk("t2_stall_tag", 32'(bus.req_tag), 4);
      end
      chk("t2_stall_count", log_q.size() - l0, 4);
      bus.req_ready = 1'b1;
      tick();
      chk("t2_one_more", log_q.size() - l0, 5);
      chk("t2_limit_again", 32'(bus.req_valid), 0);
      repeat (2) tick();
      chk("t2_still_five", log_q.size() - l0, 5);

      // reset in the middle of a job
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_valid", 32'(bus.req_valid), 0);
      chk("rst_mid_busy", 32'(bus.busy), 0);
      chk("rst_mid_err", 32'(bus.err), 0);
      tick();
      rst_n = 1'b1;
      tick();
      auto_en = 1'b1;
      l0 = log_q.size();
      cfg(1'b0, 32'h100, 3'd1, 4'd3);
      wait_done(0, 40);
      repeat (3) tick();
      chk("rst_new_count", log_q.size() - l0, 3);
      for (int i = 0; i < 3; i++) begin
         chk("rst_new_addr", log_q[l0+i].addr, 32'h100 + 2 * i);
         chk("rst_new_tag", 32'(log_q[l0+i].tag), i);
      end
      chk("rst_new_err", 32'(bus.err), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
